// File: rtl/drone_pkg.sv
// Shared constants for the telemetry downlink: frame headers, length, byte count,
// FSM state type and baud divisor helper. TLM_SEQ_EN adds a sequence byte.
package drone_pkg;

  localparam logic [7:0] TLM_HDR0 = 8'hAA;
  localparam logic [7:0] TLM_HDR1 = 8'h55;

`ifdef TLM_SEQ_EN
  localparam logic [7:0] TLM_LEN = 8'h12;
  localparam int TLM_BYTES = 22;
`else
  localparam logic [7:0] TLM_LEN = 8'h11;
  localparam int TLM_BYTES = 21;
`endif

  // Payload = everything between LEN and CHK.
  localparam int TLM_PAY = TLM_BYTES - 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    DONE
  } tlm_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: tx_start/tx_data in, tx_busy/TxD out.
// Each of start, 8 data (LSB first) and stop bit lasts DIV clocks.
module uart_byte_tx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       TxD
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [3:0]    bitn;
  logic [7:0]    sh;

  // bitn: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      TxD     <= 1'b1;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        TxD     <= 1'b0;
        cnt     <= '0;
        bitn    <= '0;
        sh      <= tx_data;
      end
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
      if (bitn == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        bitn <= bitn + 4'd1;
        TxD  <= (bitn == 4'd8) ? 1'b1 : sh[0];
        sh   <= {1'b0, sh[7:1]};
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/telemetry_tx.sv
// UART telemetry framer: snapshots attitude + duties, sends AA 55 LEN payload CHK.
// Ports: clk, rst_n, tlm_valid/tlm_ready, pitch/roll/yaw, duty_1..4, TxD, frame_done, drop_cnt. Macro: TLM_SEQ_EN.
module telemetry_tx
  import drone_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tlm_valid,
  output logic        tlm_ready,
  input  logic [23:0] pitch,
  input  logic [23:0] roll,
  input  logic [23:0] yaw,
  input  logic [15:0] duty_1,
  input  logic [15:0] duty_2,
  input  logic [15:0] duty_3,
  input  logic [15:0] duty_4,
  output logic        TxD,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int PAY_BITS = TLM_PAY * 8;
  localparam logic [4:0] LAST = 5'(TLM_BYTES - 1);

  tlm_state_t state, nxt;

  logic [4:0]          idx;
  logic [7:0]          chk;
  logic [PAY_BITS-1:0] snap;
  logic [PAY_BITS-1:0] pay_in;
  logic [7:0]          tx_byte;
  logic                tx_start;
  logic                tx_busy;
  logic                accept;
  logic                in_pay;
  logic                in_sum;

`ifdef TLM_SEQ_EN
  logic [7:0] seq;

  assign pay_in = {seq, pitch, roll, yaw,
                   duty_1, duty_2, duty_3, duty_4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq <= '0;
    else if (state == DONE) seq <= seq + 8'd1;
  end
`else
  assign pay_in = {pitch, roll, yaw,
                   duty_1, duty_2, duty_3, duty_4};
`endif

  assign tlm_ready  = (state == IDLE);
  assign frame_done = (state == DONE);
  assign tx_start   = (state == SEND);
  assign accept     = tlm_valid && tlm_ready;
  assign in_pay     = (idx >= 5'd3) && (idx < LAST);
  assign in_sum     = (idx >= 5'd2) && (idx < LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (tlm_valid) nxt = LOAD;
      LOAD: nxt = SEND;
      SEND: nxt = WAIT;
      WAIT: if (!tx_busy) nxt = (idx == LAST) ? DONE : SEND;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Payload leaves from the top of snap; it shifts one byte per payload send.
  always_comb begin
    tx_byte = snap[PAY_BITS-1 -: 8];
    unique case (1'b1)
      idx == 5'd0: tx_byte = TLM_HDR0;
      idx == 5'd1: tx_byte = TLM_HDR1;
      idx == 5'd2: tx_byte = TLM_LEN;
      idx == LAST: tx_byte = chk;
      default:     tx_byte = snap[PAY_BITS-1 -: 8];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      chk  <= '0;
      snap <= '0;
    end else begin
      if (accept) snap <= pay_in;
      if (state == LOAD) begin
        idx <= '0;
        chk <= '0;
      end
      if (state == SEND) begin
        if (in_sum) chk <= chk + tx_byte;
        if (in_pay) snap <= snap << 8;
      end
      if (state == WAIT && !tx_busy) idx <= idx + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (tlm_valid && !tlm_ready && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  uart_byte_tx #(
    .DIV (BAUD_DIV)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_byte),
    .tx_busy  (tx_busy),
    .TxD      (TxD)
  );

endmodule

// File: tb/tb_telemetry_tx.sv
// Scoreboard bench for telemetry_tx at BAUD_DIV=10: decodes TxD,
// checks every byte, bit timing, latency, drops and reset abort.
module tb_telemetry_tx;

`ifdef TLM_SEQ_EN
  localparam int NB = 22;
`else
  localparam int NB = 21;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tlm_valid = 1'b0;
  logic [23:0] pitch = '0;
  logic [23:0] roll = '0;
  logic [23:0] yaw = '0;
  logic [15:0] duty_1 = '0;
  logic [15:0] duty_2 = '0;
  logic [15:0] duty_3 = '0;
  logic [15:0] duty_4 = '0;
  logic        tlm_ready;
  logic        TxD;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  telemetry_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tlm_valid  (tlm_valid),
    .tlm_ready  (tlm_ready),
    .pitch      (pitch),
    .roll       (roll),
    .yaw        (yaw),
    .duty_1     (duty_1),
    .duty_2     (duty_2),
    .duty_3     (duty_3),
    .duty_4     (duty_4),
    .TxD        (TxD),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int acc_cyc = 0;
  int bytes_left = 0;
  int last_end = -1000;
  int seq_m = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame();
    logic [7:0]   s;
    logic [7:0]   x;
    logic [135:0] v;
    v = {pitch, roll, yaw, duty_1, duty_2, duty_3, duty_4};
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    s = (NB == 22) ? 8'h12 : 8'h11;
    exp_q.push_back(s);
    if (NB == 22) begin
      x = seq_m[7:0];
      exp_q.push_back(x);
      s = s + x;
    end
    for (int k = 0; k < 17; k++) begin
      x = v[135 - 8 * k -: 8];
      exp_q.push_back(x);
      s = s + x;
    end
    exp_q.push_back(s);
  endtask

  task automatic start_frame();
    push_frame();
    @(negedge clk);
    check("ready_idle", tlm_ready, 1);
    tlm_valid = 1'b1;
    @(negedge clk);
    tlm_valid = 1'b0;
    acc_cyc = cyc;
    bytes_left = NB;
  endtask

  task automatic wait_frame(input bit drop_on_done);
    int n;
    int fd0;
    fd0 = fd_cnt;
    n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n < 3000, 1);
    check("done_after_stop", (cyc - last_end) <= 2, 1);
    if (drop_on_done) begin
      check("ready_in_done", tlm_ready, 0);
      tlm_valid = 1'b1;
      @(negedge clk);
      tlm_valid = 1'b0;
    end
    seq_m = (seq_m + 1) % 256;
    repeat (30) @(negedge clk);
    check("done_pulses", fd_cnt - fd0, 1);
    check("queue_empty", exp_q.size(), 0);
    check("tx_idle", TxD, 1);
  endtask

  // Serial monitor: compares every cycle of each byte to the ideal waveform.
  initial begin
    int t0;
    int bad;
    int b;
    logic lvl;
    logic [7:0] e;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && TxD === 1'b0) begin
        t0 = cyc;
        if (bytes_left == NB)
          check("start_latency", t0 - acc_cyc, 2);
        else if (bytes_left > 0)
          check("byte_gap", (t0 - last_end) <= 2, 1);
        if (exp_q.size() == 0) begin
          check("extra_byte", 1, 0);
          e = 8'hFF;
        end else begin
          e = exp_q.pop_front();
        end
        if (bytes_left > 0) bytes_left--;
        bad = 0;
        d = '0;
        for (int o = 0; o < 100; o++) begin
          if (o > 0) @(negedge clk);
          if (!mon_en) break;
          b = o / 10;
          if (b == 0) lvl = 1'b0;
          else if (b == 9) lvl = 1'b1;
          else lvl = e[b - 1];
          if (TxD !== lvl) bad++;
          if (o % 10 == 5 && b >= 1 && b <= 8) d[b - 1] = TxD;
        end
        if (mon_en) begin
          check("byte", d, e);
          check("bit_shape", bad, 0);
          last_end = t0 + 100;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_txd", TxD, 1);
    check("rst_ready", tlm_ready, 1);
    check("rst_done", frame_done, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // all zero inputs
    start_frame();
    wait_frame(0);

    // single LSB set in pitch
    pitch = 24'h000001;
    start_frame();
    wait_frame(0);

    // all-ones pitch and a distinct duty_4
    pitch = 24'hFFFFFF;
    duty_4 = 16'h1234;
    start_frame();
    wait_frame(0);
    check("drop_zero", drop_cnt, 0);

    // inputs change right after the accept edge
    pitch = 24'h123456; roll = 24'hABCDEF; yaw = 24'h800001;
    duty_1 = 16'h0102; duty_2 = 16'hFEDC;
    duty_3 = 16'h7F80; duty_4 = 16'h00FF;
    start_frame();
    pitch = $urandom; roll = $urandom; yaw = $urandom;
    duty_1 = $urandom; duty_2 = $urandom;
    duty_3 = $urandom; duty_4 = $urandom;
    wait_frame(0);

    // request on the DONE->IDLE edge is a drop
    start_frame();
    wait_frame(1);
    check("drop_on_done", drop_cnt, 1);

    // flood of requests during one frame saturates drop_cnt
    pitch = 24'h0F0F0F;
    start_frame();
    repeat (300) begin
      tlm_valid = 1'b1;
      @(negedge clk);
      tlm_valid = 1'b0;
      @(negedge clk);
    end
    wait_frame(0);
    check("drop_sat", drop_cnt, 255);

    // reset mid-byte aborts the frame
    pitch = 24'h5A5A5A;
    start_frame();
    repeat (150) @(negedge clk);
    n = 0;
    while (TxD !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("found_low", TxD, 0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_txd", TxD, 1);
    check("abort_ready", tlm_ready, 1);
    check("abort_done", frame_done, 0);
    check("abort_drop", drop_cnt, 0);
    exp_q.delete();
    bytes_left = 0;
    seq_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    pitch = 24'h000100; roll = 24'h010203; yaw = 24'hFFFF00;
    duty_1 = 16'h1111; duty_2 = 16'h2222;
    duty_3 = 16'h3333; duty_4 = 16'h4444;
    start_frame();
    wait_frame(0);
    duty_4 = 16'hBEEF;
    start_frame();
    wait_frame(0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
